// File: rtl/window_pkg.sv
// Shared constants, FSM state type and width helper for the window frame buffer.
package window_pkg;

  localparam int BORDER_WRAP  = 0;
  localparam int BORDER_ZERO  = 1;
  localparam int BORDER_CLAMP = 2;

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/window_bram_if.sv
// Write, window-read and release signals of the frame buffer.
interface window_bram_if #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3
);
  import window_pkg::*;

  // one spare code point so out-of-range coordinates can be expressed
  localparam int XW = clog2(IMG_W + 1);
  localparam int YW = clog2(IMG_H + 1);

  logic                    wr_valid;
  logic                    wr_ready;
  logic [DATA_W-1:0]       wr_data;
  logic                    rd_req;
  logic                    rd_ready;
  logic [XW-1:0]           rd_x;
  logic [YW-1:0]           rd_y;
  logic                    frame_release;
  logic                    win_valid;
  logic [K*K*DATA_W-1:0]   win_data;
  logic                    rd_err;
  logic                    frame_done;

  modport master (
    output wr_valid, wr_data, rd_req, rd_x, rd_y, frame_release,
    input  wr_ready, rd_ready, win_valid, win_data, rd_err, frame_done
  );

  modport slave (
    input  wr_valid, wr_data, rd_req, rd_x, rd_y, frame_release,
    output wr_ready, rd_ready, win_valid, win_data, rd_err, frame_done
  );

endinterface

// File: rtl/window_coord.sv
// Maps one window tap coordinate (base + fixed offset) onto the frame,
// applying the selected border policy when the tap falls off the edge.
module window_coord
  import window_pkg::*;
#(
  parameter int N      = 8,
  parameter int W      = 4,
  parameter int OFF    = 0,
  parameter int BORDER = BORDER_WRAP
) (
  input  logic [W-1:0] base,
  output logic [W-1:0] idx,
  output logic         zero
);

  localparam int SW = W + 4;

  logic [SW-1:0] sum;

  always_comb begin
    sum  = SW'(base) + SW'(OFF);
    idx  = sum[W-1:0];
    zero = 1'b0;
    if (sum >= SW'(N)) begin
      // offset is at most K-1 <= N-1, so one subtraction is enough to wrap
      if (BORDER == BORDER_WRAP)      idx  = W'(sum - SW'(N));
      else if (BORDER == BORDER_ZERO) zero = 1'b1;
      else                            idx  = W'(N - 1);
    end
  end

endmodule

// File: rtl/window_bram.sv
// Frame buffer: loads one raster frame, then serves KxK windows until released.
//   state    | meaning
//   ST_LOAD  | accepting pixels in raster order, reads ignored
//   ST_READY | frame held, serving window reads until release
module window_bram
  import window_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int BORDER = BORDER_WRAP
) (
  input logic          clk,
  input logic          rst_n,
  window_bram_if.slave bus
);

  localparam int XW = clog2(IMG_W + 1);
  localparam int YW = clog2(IMG_H + 1);
  localparam int AW = clog2(IMG_W * IMG_H);
  localparam int NT = K * K;
  localparam int WW = NT * DATA_W;

  state_t            state, state_nxt;
  logic [XW-1:0]     wx;
  logic [YW-1:0]     wy;
  logic [DATA_W-1:0] mem [IMG_W*IMG_H];
  logic              wr_fire, rd_fire, last_px, range_err;
  logic [XW-1:0]     tx [K];
  logic [YW-1:0]     ty [K];
  logic              zx [K];
  logic              zy [K];
  logic [WW-1:0]     win_nxt;

  assign wr_fire   = bus.wr_valid && bus.wr_ready;
  assign rd_fire   = bus.rd_req && bus.rd_ready;
  assign last_px   = (wx == XW'(IMG_W - 1)) && (wy == YW'(IMG_H - 1));
  assign range_err = (bus.rd_x >= XW'(IMG_W)) || (bus.rd_y >= YW'(IMG_H));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:  if (wr_fire && last_px) state_nxt = ST_READY;
      ST_READY: if (bus.frame_release)  state_nxt = ST_LOAD;
      default:  state_nxt = ST_LOAD;
    endcase
  end

  always_comb begin
    bus.wr_ready = (state == ST_LOAD);
    bus.rd_ready = (state == ST_READY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wx <= '0;
      wy <= '0;
    end else if (wr_fire) begin
      if (wx == XW'(IMG_W - 1)) begin
        wx <= '0;
        wy <= last_px ? '0 : wy + 1'b1;
      end else begin
        wx <= wx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[AW'(32'(wy) * IMG_W + 32'(wx))] <= bus.wr_data;
  end

  for (genvar o = 0; o < K; o++) begin : g_off
    window_coord #(.N(IMG_W), .W(XW), .OFF(o), .BORDER(BORDER)) u_cx (
      .base(bus.rd_x), .idx(tx[o]), .zero(zx[o])
    );
    window_coord #(.N(IMG_H), .W(YW), .OFF(o), .BORDER(BORDER)) u_cy (
      .base(bus.rd_y), .idx(ty[o]), .zero(zy[o])
    );
  end

  // tap (0,0) lands in the top slice, remaining taps follow row-major toward the LSB
  always_comb begin
    win_nxt = '0;
    if (!range_err) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          if (!(zy[i] || zx[j]))
            win_nxt[(NT-1-(i*K+j))*DATA_W +: DATA_W] = mem[AW'(32'(ty[i]) * IMG_W + 32'(tx[j]))];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.win_valid  <= 1'b0;
      bus.win_data   <= '0;
      bus.rd_err     <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.win_valid  <= rd_fire;
      bus.rd_err     <= rd_fire && range_err;
      bus.frame_done <= wr_fire && last_px;
      if (rd_fire) bus.win_data <= win_nxt;
    end
  end

endmodule
